// File: rtl/pixel_pack_writer_if.sv
// Pixel-in / BRAM-write-out bundle for pixel_pack_writer.
// o_wcnt exists only when PIXEL_PACK_WCOUNT_EN is defined.
interface pixel_pack_writer_if #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [BIT_WIDTH*NUM_CHANNEL-1:0] i_dat;
  logic                             i_val;
  logic                             o_stall;
  logic                             i_end;
  logic                             i_wstall;
  logic [ADDR_WIDTH-1:0]            o_addr;
  logic                             o_wren;
  logic [DATA_WIDTH-1:0]            o_dat;
  logic                             o_done;
`ifdef PIXEL_PACK_WCOUNT_EN
  logic [31:0]                      o_wcnt;
`endif

  modport slave (
    input  i_dat, i_val, i_end, i_wstall,
`ifdef PIXEL_PACK_WCOUNT_EN
    output o_wcnt,
`endif
    output o_stall, o_addr, o_wren, o_dat, o_done
  );

  modport master (
    output i_dat, i_val, i_end, i_wstall,
`ifdef PIXEL_PACK_WCOUNT_EN
    input  o_wcnt,
`endif
    input  o_stall, o_addr, o_wren, o_dat, o_done
  );
endinterface

// File: rtl/pixel_pack_writer.sv
// Packs NUM_CHANNEL-sample pixels byte-contiguously into DATA_WIDTH BRAM writes,
// zero-padding the tail on end-of-frame. Optional word counter: PIXEL_PACK_WCOUNT_EN.
module pixel_pack_writer #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH       = 50176
) (
  input logic                 clk,
  input logic                 rst,
  pixel_pack_writer_if.slave  io_bus
);
  localparam int W  = DATA_WIDTH / BIT_WIDTH;
  localparam int P  = NUM_CHANNEL;
  localparam int PW = BIT_WIDTH * NUM_CHANNEL;
  localparam int BW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0]         C_W    = CW'(W);
  localparam logic [CW-1:0]         C_P    = CW'(P);
  localparam logic [CW-1:0]         C_LIM  = CW'(2 * W - 1 - P);
  localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(BASE_ADDR + DEPTH - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [BW-1:0]         r_buf, w_shift, w_pix, w_buf_nxt;
  logic [CW-1:0]         r_b, w_rem, w_b_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_cnt, r_addr, w_addr_inc;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_wren;
  logic                  w_full, w_emit, w_stall, w_acc;

  always_comb begin
    w_full = (r_b >= C_W);
    // A sub-word tail only leaves the buffer while flushing.
    w_emit = !io_bus.i_wstall && (w_full || (r_state == S_FLUSH && r_b != '0));
    w_rem  = r_b;
    if (w_emit) w_rem = w_full ? (r_b - C_W) : '0;
    // Counting the same-cycle emit keeps one pixel/cycle flowing; this makes
    // o_stall depend combinationally on i_wstall.
    w_stall   = (r_state != S_RUN) || (w_rem > C_LIM);
    w_acc     = io_bus.i_val && !w_stall;
    w_shift   = w_emit ? {{DATA_WIDTH{1'b0}}, r_buf[BW-1:DATA_WIDTH]} : r_buf;
    w_pix     = BW'(io_bus.i_dat) << (BIT_WIDTH * int'(w_rem));
    w_buf_nxt = w_acc ? (w_shift | w_pix) : w_shift;
    w_b_nxt   = w_acc ? (w_rem + C_P) : w_rem;
    w_addr_inc = (r_addr_cnt == C_LAST) ? C_BASE : r_addr_cnt + ADDR_WIDTH'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (io_bus.i_end) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_b == '0)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_buf      <= '0;
      r_b        <= '0;
      r_addr_cnt <= C_BASE;
      r_addr     <= C_BASE;
      r_dat      <= '0;
      r_wren     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wren  <= w_emit;
      if (w_emit) begin
        r_dat      <= r_buf[DATA_WIDTH-1:0];
        r_addr     <= r_addr_cnt;
        r_addr_cnt <= w_addr_inc;
      end
      if (r_state == S_DONE) begin
        r_b        <= '0;
        r_buf      <= '0;
        r_addr_cnt <= C_BASE;
      end else begin
        r_b   <= w_b_nxt;
        r_buf <= w_buf_nxt;
      end
    end
  end

`ifdef PIXEL_PACK_WCOUNT_EN
  logic [31:0] r_wcnt;
  always_ff @(posedge clk) begin
    if (!rst)                  r_wcnt <= '0;
    else if (r_state == S_DONE) r_wcnt <= '0;
    else if (w_emit)           r_wcnt <= r_wcnt + 32'd1;
  end
  assign io_bus.o_wcnt = r_wcnt;
`endif

  assign io_bus.o_stall = w_stall;
  assign io_bus.o_wren  = r_wren;
  assign io_bus.o_dat   = r_dat;
  assign io_bus.o_addr  = r_addr;
  assign io_bus.o_done  = (r_state == S_DONE);
endmodule
